// File: rtl/mips32_pkg.sv
// Shared definitions for the MIPS32 program loader and its pipeline neighbour.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips32_pkg;

    // Loader states; CSUM and ERR are only reachable in the checksum build.
    typedef enum logic [2:0] {
        ST_HDR   = 3'd0,
        ST_DATA  = 3'd1,
        ST_CSUM  = 3'd2,
        ST_ERR   = 3'd3,
        ST_START = 3'd4,
        ST_RUN   = 3'd5
    } ld_state_t;

    // Header word layout: base address in the upper half, word count in the lower half.
    localparam int ADDR_MSB = 31;
    localparam int ADDR_LSB = 16;
    localparam int CNT_MSB  = 15;
    localparam int CNT_LSB  = 0;

    // Opcode of the HLT instruction that ends a program run.
    localparam logic [5:0] HLT_OP = 6'h3F;

    // States in which the loader accepts stream words.
    function automatic logic state_accepts(input ld_state_t s);
        return (s == ST_HDR) || (s == ST_DATA) || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/mips32_loader_csum.sv
// Running 32-bit wrapping sum of a segment's data words, compared against a trailer word.
// Latency: sum updates one cycle after add; match is combinational on cmp_data.
// Backpressure: none; the caller qualifies clear/add with its own handshake.
module mips32_loader_csum #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          add,
    input  logic [DW-1:0] add_data,
    input  logic [DW-1:0] cmp_data,
    output logic          match
);

    logic [DW-1:0] sum;

    // Accumulator: clear at segment start, add each accepted data word.
    always_ff @(posedge clk) begin
        if (reset) begin
            sum <= '0;
        end else if (clear) begin
            sum <= '0;
        end else if (add) begin
            sum <= sum + add_data;
        end
    end

    assign match = (sum == cmp_data);

endmodule

// File: rtl/mips32_prog_loader.sv
// Streams header/data(/checksum) words into CPU memory, then launches the CPU and waits for HLT.
// Latency: memory write registered one cycle after each data transfer; launch pulse one cycle after the launch header.
// Backpressure: in_ready high only while loading; low in START/RUN/ERR. Checksum trailer enabled by MIPS32_LOADER_CHECKSUM_EN.
import mips32_pkg::*;

module mips32_prog_loader #(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          cpu_hold,
    output logic          cpu_start,
    output logic [31:0]   cpu_pc,
    input  logic          cpu_halted,
    output logic          busy,
    output logic          err,
    output logic [15:0]   words_loaded
);

    ld_state_t     state;
    ld_state_t     state_nxt;
    logic [AW-1:0] ptr;
    logic [15:0]   rem;
    logic          take;
    logic [15:0]   hdr_base;
    logic [15:0]   hdr_cnt;
    logic          hdr_take;
    logic          data_take;

    assign take      = in_valid & in_ready;
    assign hdr_base  = in_data[ADDR_MSB:ADDR_LSB];
    assign hdr_cnt   = in_data[CNT_MSB:CNT_LSB];
    assign hdr_take  = take && (state == ST_HDR);
    assign data_take = take && (state == ST_DATA);

`ifdef MIPS32_LOADER_CHECKSUM_EN
    logic csum_match;

    mips32_loader_csum #(.DW(DW)) u_csum (
        .clk      (clk),
        .reset    (reset),
        .clear    (hdr_take),
        .add      (data_take),
        .add_data (in_data),
        .cmp_data (in_data),
        .match    (csum_match)
    );
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_HDR;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; cpu_halted only matters once the CPU is actually running.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_HDR: begin
                if (take) begin
                    state_nxt = (hdr_cnt != 16'd0) ? ST_DATA : ST_START;
                end
            end
            ST_DATA: begin
                if (take && (rem == 16'd1)) begin
`ifdef MIPS32_LOADER_CHECKSUM_EN
                    state_nxt = ST_CSUM;
`else
                    state_nxt = ST_HDR;
`endif
                end
            end
`ifdef MIPS32_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (take) begin
                    state_nxt = csum_match ? ST_HDR : ST_ERR;
                end
            end
            ST_ERR: begin
                state_nxt = ST_ERR;
            end
`endif
            ST_START: begin
                state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (cpu_halted) begin
                    state_nxt = ST_HDR;
                end
            end
            default: begin
                state_nxt = ST_HDR;
            end
        endcase
    end

    // Control outputs registered from the next state, so they line up with the state itself;
    // the reset values hold in_ready low for the first cycle out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready  <= 1'b0;
            cpu_hold  <= 1'b1;
            cpu_start <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            in_ready  <= state_accepts(state_nxt);
            cpu_hold  <= !((state_nxt == ST_START) || (state_nxt == ST_RUN));
            cpu_start <= (state_nxt == ST_START);
            busy      <= (state_nxt != ST_HDR);
`ifdef MIPS32_LOADER_CHECKSUM_EN
            err       <= (state_nxt == ST_ERR);
`else
            err       <= 1'b0;
`endif
        end
    end

    // Datapath: segment pointer/count, registered memory write, launch PC and word counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr          <= '0;
            rem          <= '0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            cpu_pc       <= '0;
            words_loaded <= '0;
        end else begin
            mem_we <= 1'b0;
            if (hdr_take) begin
                ptr <= hdr_base[AW-1:0];
                rem <= hdr_cnt;
                if (hdr_cnt == 16'd0) begin
                    cpu_pc <= {16'b0, hdr_base};
                end
            end
            if (data_take) begin
                mem_we    <= 1'b1;
                mem_addr  <= ptr;
                mem_wdata <= in_data;
                ptr       <= ptr + AW'(1);
                rem       <= rem - 16'd1;
                if (words_loaded != 16'hFFFF) begin
                    words_loaded <= words_loaded + 16'd1;
                end
            end
            if ((state == ST_RUN) && cpu_halted) begin
                words_loaded <= '0;
            end
        end
    end

endmodule
